// File: rtl/uart_tx.sv
// uart_tx: serial transmit stage of the UART datapath.
// Pops one byte at a time from the transmit FIFO through the have_next/next
// handshake and shifts it out LSB first as an 8N1 or 8N2 asynchronous frame.
// Every bit is held for exactly CLK_DIV clock cycles. All outputs are registered.

module uart_tx #(
    parameter int CLK_DIV   = 104,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       have_next_i,
    input  logic [7:0] data_i,
    output logic       next_o,
    output logic       tx_o,
    output logic       busy_o
);

    // Baud counter is wide enough to hold CLK_DIV-1; CLK_DIV >= 2 keeps it >= 1 bit.
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       shift_q;
    logic [7:0]       shift_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic             stop_idx;
    logic             stop_idx_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_next;
    logic             tx_next;
    logic             pop_next;
    logic             busy_next;

    // A new frame may start only when transmission is enabled and the FIFO has a byte.
    logic             load;
    // Last cycle of the current bit period.
    logic             period_end;
    // Another stop bit still has to follow the one that is ending.
    logic             more_stops;

    assign load       = enable_i && have_next_i;
    assign period_end = (baud_cnt == '0);
    assign more_stops = (int'(stop_idx) + 1) < STOP_BITS;

    // State register; reset drops any frame in flight immediately.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic; every target holds unless a rule below changes it.
    always_comb begin
        state_next    = state;
        shift_next    = shift_q;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        baud_cnt_next = baud_cnt;
        tx_next       = tx_o;
        pop_next      = 1'b0;

        if (state != IDLE) begin
            // Bit timing runs in every active state and reloads at each period end.
            baud_cnt_next = period_end ? RELOAD : (baud_cnt - CNT_W'(1));
        end

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (load) begin
                    shift_next    = data_i;
                    pop_next      = 1'b1;
                    tx_next       = 1'b0;
                    baud_cnt_next = RELOAD;
                    state_next    = START;
                end
            end

            START: begin
                if (period_end) begin
                    tx_next      = shift_q[0];
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end
            end

            DATA: begin
                if (period_end) begin
                    if (bit_idx != 3'd7) begin
                        // Shift right so the next data bit sits in bit 1 of the old value.
                        shift_next   = {1'b0, shift_q[7:1]};
                        tx_next      = shift_q[1];
                        bit_idx_next = bit_idx + 3'd1;
                    end else begin
                        tx_next       = 1'b1;
                        stop_idx_next = 1'b0;
                        state_next    = STOP;
                    end
                end
            end

            STOP: begin
                if (period_end) begin
                    if (more_stops) begin
                        stop_idx_next = 1'b1;
                    end else if (load) begin
                        // Chain straight into the next start bit: no idle gap between frames.
                        shift_next    = data_i;
                        pop_next      = 1'b1;
                        tx_next       = 1'b0;
                        baud_cnt_next = RELOAD;
                        state_next    = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // Datapath and output registers; reset forces the line high with no partial stop bit.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            shift_q  <= 8'h00;
            bit_idx  <= 3'd0;
            stop_idx <= 1'b0;
            baud_cnt <= '0;
            tx_o     <= 1'b1;
            next_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            shift_q  <= shift_next;
            bit_idx  <= bit_idx_next;
            stop_idx <= stop_idx_next;
            baud_cnt <= baud_cnt_next;
            tx_o     <= tx_next;
            next_o   <= pop_next;
            busy_o   <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized bench for uart_tx.
// Four instances with different divisors / stop-bit counts are fed from
// behavioural FIFO queues; the serial lines are recorded every cycle and decoded
// by a reference UART receiver that checks bit-cell timing and framing.
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en   [N];
    logic       hn   [N];
    logic [7:0] dat  [N];
    logic       nx   [N];
    logic       tx   [N];
    logic       bz   [N];

    logic [7:0] fq   [N][$];
    logic [7:0] sent [N][$];
    bit         rtx  [N][$];
    bit         rbz  [N][$];
    int         pops [N];
    int         rb   [N];
    int         pb   [N];
    int         divv [N];
    int         sbv  [N];

    logic [7:0] dec [$];
    int         dstart [$];
    int         bad_cells;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_DIV(4), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .reset_i(reset_n), .enable_i(en[0]), .have_next_i(hn[0]),
        .data_i(dat[0]), .next_o(nx[0]), .tx_o(tx[0]), .busy_o(bz[0]));
    uart_tx #(.CLK_DIV(3), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .reset_i(reset_n), .enable_i(en[1]), .have_next_i(hn[1]),
        .data_i(dat[1]), .next_o(nx[1]), .tx_o(tx[1]), .busy_o(bz[1]));
    uart_tx #(.CLK_DIV(2), .STOP_BITS(1)) dut_c (
        .clk_i(clk), .reset_i(reset_n), .enable_i(en[2]), .have_next_i(hn[2]),
        .data_i(dat[2]), .next_o(nx[2]), .tx_o(tx[2]), .busy_o(bz[2]));
    uart_tx #(.CLK_DIV(16), .STOP_BITS(1)) dut_d (
        .clk_i(clk), .reset_i(reset_n), .enable_i(en[3]), .have_next_i(hn[3]),
        .data_i(dat[3]), .next_o(nx[3]), .tx_o(tx[3]), .busy_o(bz[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start a fresh observation window for instance i.
    task automatic mark(input int i);
        rb[i] = rtx[i].size();
        pb[i] = pops[i];
    endtask

    // Reference receiver: find each start bit, check every sample of every cell,
    // sample data mid-cell, require high stop cells.
    function automatic void decode(input int i, input int div, input int sb);
        int k;
        int len;
        k = rb[i];
        len = (9 + sb) * div;
        dec.delete();
        dstart.delete();
        bad_cells = 0;
        while (k + len <= rtx[i].size()) begin
            if (rtx[i][k] == 1'b0) begin
                logic [7:0] b;
                b = 8'h00;
                for (int c = 0; c < 9 + sb; c++) begin
                    for (int j = 0; j < div; j++) begin
                        bit e;
                        e = (c == 0) ? 1'b0 : ((c <= 8) ? rtx[i][k + c*div] : 1'b1);
                        if (rtx[i][k + c*div + j] != e) bad_cells++;
                    end
                end
                for (int d = 0; d < 8; d++) b[d] = rtx[i][k + (d + 1)*div + div/2];
                dec.push_back(b);
                dstart.push_back(k);
                k += len;
            end else begin
                k++;
            end
        end
    endfunction

    function automatic int zeros(input int i, input int from, input int upto);
        int z;
        z = 0;
        for (int k = from; k < upto; k++)
            if (k >= rtx[i].size() || rtx[i][k] == 1'b0) z++;
        return z;
    endfunction

    function automatic void busy_stats(input int i, output int cnt, output int span);
        int first;
        int last;
        first = -1;
        last = -1;
        cnt = 0;
        for (int k = rb[i]; k < rbz[i].size(); k++) begin
            if (rbz[i][k]) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
            end
        end
        span = (first < 0) ? 0 : last - first + 1;
    endfunction

    // FIFO model outputs and line recorder, updated on the falling edge.
    initial begin
        for (int i = 0; i < N; i++) begin
            hn[i] = 1'b0;
            dat[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                hn[i]  = (fq[i].size() > 0);
                dat[i] = (fq[i].size() > 0) ? fq[i][0] : 8'($urandom);
                if (nx[i] === 1'b1) chk("pop_with_start", tx[i], 1'b0);
                rtx[i].push_back(tx[i]);
                rbz[i].push_back(bz[i]);
            end
        end
    end

    // FIFO pop side: one byte leaves the queue per next_o cycle.
    initial begin
        for (int i = 0; i < N; i++) pops[i] = 0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (nx[i] === 1'b1) begin
                    pops[i]++;
                    chk("pop_nonempty", fq[i].size() > 0, 1'b1);
                    if (fq[i].size() > 0) void'(fq[i].pop_front());
                end
            end
        end
    end

    initial begin
        int cnt;
        int span;
        int s;
        int errs;
        int k;
        int pending;
        int left [N];
        logic [7:0] b;
        bit a5_bits [10];

        a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        divv = '{4, 3, 2, 16};
        sbv  = '{1, 2, 1, 1};
        for (int i = 0; i < N; i++) en[i] = 1'b1;

        // Reset state
        #1 reset_n = 1'b0;
        cycles(3);
        for (int i = 0; i < N; i++) begin
            chk("rst_tx", tx[i], 1'b1);
            chk("rst_next", nx[i], 1'b0);
            chk("rst_busy", bz[i], 1'b0);
        end
        reset_n = 1'b1;
        cycles(2);

        // Single byte 0xA5, CLK_DIV=4
        mark(0);
        fq[0].push_back(8'hA5);
        cycles(60);
        decode(0, 4, 1);
        chk("a5_frames", dec.size(), 1);
        if (dec.size() > 0) chk("a5_byte", dec[0], 8'hA5);
        chk("a5_cells", bad_cells, 0);
        s = (dstart.size() > 0) ? dstart[0] : rb[0];
        errs = 0;
        for (int c = 0; c < 10; c++)
            for (int j = 0; j < 4; j++)
                if (s + c*4 + j >= rtx[0].size() || rtx[0][s + c*4 + j] != a5_bits[c]) errs++;
        chk("a5_wave", errs, 0);
        chk("a5_pops", pops[0] - pb[0], 1);
        busy_stats(0, cnt, span);
        chk("a5_busy_cnt", cnt, 40);
        chk("a5_busy_span", span, 40);
        chk("a5_idle_after", bz[0], 1'b0);

        // Back-to-back 0x00, 0xFF
        mark(0);
        fq[0].push_back(8'h00);
        fq[0].push_back(8'hFF);
        cycles(100);
        decode(0, 4, 1);
        chk("b2b_frames", dec.size(), 2);
        if (dec.size() == 2) begin
            chk("b2b_byte0", dec[0], 8'h00);
            chk("b2b_byte1", dec[1], 8'hFF);
            chk("b2b_gap", dstart[1] - dstart[0], 40);
        end
        chk("b2b_cells", bad_cells, 0);
        chk("b2b_pops", pops[0] - pb[0], 2);
        busy_stats(0, cnt, span);
        chk("b2b_busy_cnt", cnt, 80);
        chk("b2b_busy_span", span, 80);

        // Enable gating
        mark(0);
        en[0] = 1'b0;
        fq[0].push_back(8'h3C);
        cycles(50);
        chk("gate_no_pop", pops[0] - pb[0], 0);
        chk("gate_idle_line", zeros(0, rb[0], rtx[0].size()), 0);
        en[0] = 1'b1;
        k = 0;
        while (bz[0] !== 1'b1 && k < 20) begin
            cycles(1);
            k++;
        end
        chk("gate_started", bz[0], 1'b1);
        cycles(10);
        en[0] = 1'b0;
        fq[0].push_back(8'h55);
        cycles(60);
        decode(0, 4, 1);
        chk("gate_frames", dec.size(), 1);
        if (dec.size() > 0) chk("gate_byte", dec[0], 8'h3C);
        chk("gate_cells", bad_cells, 0);
        chk("gate_pops", pops[0] - pb[0], 1);
        chk("gate_left_queued", fq[0].size(), 1);
        chk("gate_idle_busy", bz[0], 1'b0);
        fq[0].delete();
        cycles(2);

        // Two stop bits, CLK_DIV=3: 0x81
        mark(1);
        fq[1].push_back(8'h81);
        cycles(50);
        decode(1, 3, 2);
        chk("sb2_frames", dec.size(), 1);
        if (dec.size() > 0) chk("sb2_byte", dec[0], 8'h81);
        chk("sb2_cells", bad_cells, 0);
        s = (dstart.size() > 0) ? dstart[0] : rb[1];
        chk("sb2_stop_high", zeros(1, s + 27, s + 33), 0);
        busy_stats(1, cnt, span);
        chk("sb2_busy_cnt", cnt, 33);
        chk("sb2_pops", pops[1] - pb[1], 1);

        // Reset in the middle of a data bit
        en[0] = 1'b1;
        fq[0].push_back(8'h00);
        cycles(14);
        chk("rm_busy_before", bz[0], 1'b1);
        chk("rm_tx_before", tx[0], 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("rm_tx", tx[0], 1'b1);
        chk("rm_next", nx[0], 1'b0);
        chk("rm_busy", bz[0], 1'b0);
        cycles(2);
        reset_n = 1'b1;
        mark(0);
        cycles(100);
        chk("rm_idle_line", zeros(0, rb[0], rtx[0].size()), 0);
        chk("rm_no_pop", pops[0] - pb[0], 0);

        // Randomized traffic on all four instances (200 bytes total)
        for (int i = 0; i < N; i++) begin
            mark(i);
            sent[i].delete();
            left[i] = 50;
            en[i] = 1'b1;
        end
        k = 0;
        pending = 1;
        while (pending != 0 && k < 40000) begin
            for (int i = 0; i < N; i++) begin
                if (left[i] > 0 && fq[i].size() < 3 && $urandom_range(0, 7) == 0) begin
                    b = 8'($urandom);
                    fq[i].push_back(b);
                    sent[i].push_back(b);
                    left[i]--;
                end
            end
            cycles(1);
            k++;
            pending = 0;
            for (int i = 0; i < N; i++)
                pending += left[i] + fq[i].size() + ((bz[i] === 1'b1) ? 1 : 0);
        end
        chk("rand_done", pending, 0);
        cycles(5);
        for (int i = 0; i < N; i++) begin
            decode(i, divv[i], sbv[i]);
            chk("rand_frames", dec.size(), sent[i].size());
            for (int j = 0; j < dec.size() && j < sent[i].size(); j++)
                chk("rand_byte", dec[j], sent[i][j]);
            chk("rand_cells", bad_cells, 0);
            chk("rand_pops", pops[i] - pb[i], sent[i].size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
